// File: rtl/byte_bank_pkg.sv
// -----------------------------------------------------------------------------
// byte_bank_pkg
// Shared constants, the scan FSM state type and a small entry-select helper
// for the byte bank scanner slice (byte_bank_regs, byte_bank_scanner).
// -----------------------------------------------------------------------------
package byte_bank_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    // Index of the final entry in a pass; the scan either stops or wraps here.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Pull entry idx out of the flat bank bus. Written as a compare loop so it
    // maps to a plain 8:1 byte mux without any variable-width arithmetic.
    function automatic logic [DATA_W-1:0] pick_entry(
        input logic [DEPTH*DATA_W-1:0] flat,
        input logic [ADDR_W-1:0]       idx
    );
        logic [DATA_W-1:0] result;
        result = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (idx == k[ADDR_W-1:0]) begin
                result = flat[k*DATA_W +: DATA_W];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_bank_regs.sv
// -----------------------------------------------------------------------------
// byte_bank_regs
// 8 x 8-bit register bank with a single write port. Every entry is driven in
// parallel onto a flat 64-bit bus (entry k on bits [8k+7:8k]) that feeds the
// downstream 8-way byte selector directly.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high; clears every entry to 0x00
//   wr_en      - write strobe
//   wr_addr    - entry index to write
//   wr_data    - byte to write
//   entry_flat - all entries, entry k on bits [8k+7:8k]
// -----------------------------------------------------------------------------
module byte_bank_regs
    import byte_bank_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DEPTH*DATA_W-1:0] entry_flat
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage update. Reset wins over a simultaneous write so the bank is
    // guaranteed all-zero the cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Flatten the bank onto the selector input bus.
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign entry_flat[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/byte_bank_scanner.sv
// -----------------------------------------------------------------------------
// byte_bank_scanner
// Register bank feeding an 8-way byte selector, plus a scan engine that walks
// entries 0..7 and streams them out over a valid/ready interface. sel always
// names the entry currently held in out_data while out_valid is high, so the
// external selector output tracks out_data.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high; aborts any scan, clears the bank
//   wr_en      - bank write strobe (accepted in every state)
//   wr_addr    - bank write index
//   wr_data    - bank write data
//   start      - one-cycle pulse, begins a scan when idle
//   entry_flat - all entries, entry k on bits [8k+7:8k]; selector in_k
//   sel        - current scan index; selector select
//   out_data   - registered scanned byte
//   out_valid  - out_data holds a byte not yet accepted
//   out_ready  - consumer accepts out_data
//   busy       - high while scanning
//   done       - one-cycle pulse after the last entry is accepted
//
// Build option:
//   BYTE_BANK_SCAN_LOOP_EN - when defined, the scan wraps from entry 7 back to
//   entry 0 indefinitely, pulsing done on every wrap; stops only on reset.
// -----------------------------------------------------------------------------
module byte_bank_scanner
    import byte_bank_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    start,
    output logic [DEPTH*DATA_W-1:0] entry_flat,
    output logic [ADDR_W-1:0]       sel,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    scan_state_t       state;
    logic [ADDR_W-1:0] load_idx;
    logic [DATA_W-1:0] load_byte;
    logic              handshake;

    byte_bank_regs u_regs (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .entry_flat (entry_flat)
    );

    assign handshake = out_valid && out_ready;

    // Work out which entry would be loaded into out_data on the next edge and
    // what byte that is. From IDLE the first load is always entry 0; in SCAN it
    // is the next index, which naturally wraps 7 -> 0 for the looping build.
    // A write landing on that same entry this cycle is forwarded straight
    // through, because the bank itself only updates at the edge.
    always_comb begin
        load_idx = sel + ADDR_W'(1);
        if (state == IDLE) begin
            load_idx = '0;
        end
        load_byte = pick_entry(entry_flat, load_idx);
        if (wr_en && (wr_addr == load_idx)) begin
            load_byte = wr_data;
        end
    end

    // Scan FSM with registered outputs. out_data/sel only move on an accepted
    // handshake, which keeps the byte stable for a stalled consumer. done
    // defaults low every cycle and is raised only on the edge that finishes a
    // pass, so it is always a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        sel       <= '0;
                        out_data  <= load_byte;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (handshake) begin
                        if (sel != LAST_IDX) begin
                            sel      <= load_idx;
                            out_data <= load_byte;
                        end else begin
`ifdef BYTE_BANK_SCAN_LOOP_EN
                            sel      <= load_idx;
                            out_data <= load_byte;
                            done     <= 1'b1;
`else
                            state     <= DONE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    sel   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_bank_scanner.sv
// -----------------------------------------------------------------------------
// tb_byte_bank_scanner
// Scoreboard bench for byte_bank_scanner. Expected bytes (with their index)
// are queued when a scan is launched and popped by a negedge monitor on every
// accepted handshake; the monitor also expects exactly one done pulse in the
// cycle after each entry-7 acceptance.
// -----------------------------------------------------------------------------
module tb_byte_bank_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic [63:0] entry_flat;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int          assert_count = 0;
    int          fail_count = 0;
    int          done_count = 0;
    logic        done_pending = 1'b0;
    logic [10:0] exp_q[$];
    logic [7:0]  model_mem [8];

    always #5 clk = ~clk;

    byte_bank_scanner dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .entry_flat (entry_flat),
        .sel        (sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle bank write, mirrored into the bench model.
    task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        model_mem[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) model_mem[k] = 8'h00;
    endtask

    // Queue one full pass of expected {index, byte} pairs from the model.
    task automatic pushScan();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({k[2:0], model_mem[k]});
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitSel(input logic [2:0] s);
        int n;
        n = 0;
        while (!(out_valid && sel == s) && n < 40) begin
            tick();
            n++;
        end
        checkOutput("wait_sel", {63'd0, (out_valid && sel == s)}, 64'd1);
    endtask

    task automatic waitDone(input int target);
        int n;
        n = 0;
        while (done_count < target && n < 60) begin
            tick();
            n++;
        end
        checkOutput("wait_done", done_count, target);
    endtask

    // Monitor: done must follow an entry-7 acceptance by exactly one cycle,
    // and every accepted byte must match the head of the scoreboard.
    initial begin
        logic [10:0] e;
        logic        nxt;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_pending = 1'b0;
            end else begin
                checkOutput("done_pulse", {63'd0, done}, {63'd0, done_pending});
                if (done) done_count++;
                nxt = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("sb_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("scan_data", out_data, e[7:0]);
                        checkOutput("scan_sel", sel, e[10:8]);
                        nxt = (e[10:8] == 3'd7);
                    end
                end
                done_pending = nxt;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting byte_bank_scanner bench");
        doReset();

        // Reset state
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sel", sel, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_bank", entry_flat, 0);

        for (int k = 0; k < 8; k++) applyStimulus(k[2:0], 8'(k * 8'h11));
        checkOutput("bank_load", entry_flat, 64'h7766554433221100);

`ifdef BYTE_BANK_SCAN_LOOP_EN
        // Looping scan: three passes with ready held high, done on each wrap.
        out_ready = 1'b1;
        pushScan();
        pushScan();
        pushScan();
        pulseStart();
        checkOutput("loop_first_valid", out_valid, 1);
        repeat (24) tick();
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("loop_done_count", done_count, 3);
        checkOutput("loop_busy", busy, 1);
        checkOutput("loop_valid", out_valid, 1);
        checkOutput("loop_sel_wrapped", sel, 0);
        checkOutput("loop_data_wrapped", out_data, 8'h00);
`else
        // Full-rate scan: bytes t+1..t+8, done at t+9.
        out_ready = 1'b1;
        pushScan();
        pulseStart();
        checkOutput("s1_valid_lat", out_valid, 1);
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_sel0", sel, 0);
        repeat (8) tick();
        checkOutput("s1_done_t9", done, 1);
        checkOutput("s1_busy_end", busy, 0);
        checkOutput("s1_valid_end", out_valid, 0);
        checkOutput("s1_sel_hold7", sel, 7);
        tick();
        checkOutput("s1_sel_idle", sel, 0);
        checkOutput("s1_done_count", done_count, 1);

        // Stall while 0x22 is presented.
        pushScan();
        pulseStart();
        waitSel(3'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_data", out_data, 8'h22);
            checkOutput("stall_sel", sel, 2);
            checkOutput("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        waitDone(2);
        tick();

        // Write-first bypass on entry 4, late write to entry 1.
        model_mem[4] = 8'hA5;
        pushScan();
        pulseStart();
        waitSel(3'd3);
        applyStimulus(3'd4, 8'hA5);
        applyStimulus(3'd1, 8'h5A);
        checkOutput("late_write_bank", entry_flat[15:8], 8'h5A);
        checkOutput("bypass_bank", entry_flat[39:32], 8'hA5);
        waitDone(3);
        tick();

        // start mid-scan must not restart the pass.
        pushScan();
        pulseStart();
        waitSel(3'd3);
        pulseStart();
        waitDone(4);
        repeat (4) tick();
        checkOutput("single_done", done_count, 4);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_valid", out_valid, 0);

        // Reset mid-scan at sel 5.
        pushScan();
        pulseStart();
        waitSel(3'd5);
        doReset();
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_sel", sel, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_bank", entry_flat, 0);
        tick();
        checkOutput("abort_done_count", done_count, 4);
`endif

        checkOutput("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
